// File: rtl/hvsync_generator.sv
// Free-running VGA-style raster timing generator: pixel/line counters plus
// registered sync and display-enable strobes aligned with the visible counters.
module hvsync_generator #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS        = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS        = 11'(V_DISPLAY);
  localparam logic [10:0] H_SYNC_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  logic       h_wrap;
  logic [10:0] h_ext, v_ext;

  always_comb begin
    h_wrap = (hpos_q == H_LAST);
    hpos_d = h_wrap ? '0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (h_wrap) begin
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
    end
  end

  // Strobes decode the next counter values so they land in the same cycle
  // as the hpos/vpos they describe.
  always_comb begin
    h_ext   = {1'b0, hpos_d};
    v_ext   = {1'b0, vpos_d};
    hsync_d = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    disp_d  = (h_ext < H_VIS) && (v_ext < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      disp_q  <= 1'b1;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = disp_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: three configurations checked every cycle against
// a cycle-count model (position = elapsed clocks div/mod the line/frame totals).
module tb_hvsync_generator;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } vid_t;

  // Small raster so whole frames fit in a short run.
  localparam int SHD = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVD = 6, SVF = 2, SVS = 2, SVB = 2;
  // Reduced line width with positive polarities.
  localparam int PHD = 320, PHF = 8, PHS = 32, PHB = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint n = 0;

  // Clocks elapsed since reset release; everything expected derives from this.
  always @(posedge clk or negedge reset) begin
    if (!reset) n <= 0;
    else        n <= n + 1;
  end

  logic       a_hs, a_vs, a_de; logic [9:0] a_h, a_v;
  logic       b_hs, b_vs, b_de; logic [9:0] b_h, b_v;
  logic       c_hs, c_vs, c_de; logic [9:0] c_h, c_v;
  vid_t obs_a, obs_b, obs_c;
  assign obs_a = {a_h, a_v, a_hs, a_vs, a_de};
  assign obs_b = {b_h, b_v, b_hs, b_vs, b_de};
  assign obs_c = {c_h, c_v, c_hs, c_vs, c_de};

  hvsync_generator dut_def (
    .clk(clk), .reset(reset), .hsync(a_hs), .vsync(a_vs),
    .display_on(a_de), .hpos(a_h), .vpos(a_v)
  );

  hvsync_generator #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_small (
    .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .hpos(b_h), .vpos(b_v)
  );

  hvsync_generator #(
    .H_DISPLAY(PHD), .H_FRONT(PHF), .H_SYNC(PHS), .H_BACK(PHB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_pol (
    .clk(clk), .reset(reset), .hsync(c_hs), .vsync(c_vs),
    .display_on(c_de), .hpos(c_h), .vpos(c_v)
  );

  function automatic vid_t ref_pos(longint cnt, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb, bit hp, bit vp);
    vid_t   r;
    longint ht = hd + hf + hs + hb;
    longint vt = vd + vf + vs + vb;
    longint h  = cnt % ht;
    longint v  = (cnt / ht) % vt;
    r.h  = 10'(h);
    r.v  = 10'(v);
    r.hs = (h >= hd + hf && h < hd + hf + hs) ? hp : !hp;
    r.vs = (v >= vd + vf && v < vd + vf + vs) ? vp : !vp;
    r.de = (h < hd) && (v < vd);
    return r;
  endfunction

  task automatic test_free_run(input int cycles);
    vid_t e;
    repeat (cycles) begin
      @(negedge clk);
      e = ref_pos(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      checks++;
      if (obs_a !== e) begin
        errors++;
        $display("FAIL def_cycle n=%0d got h=%0d v=%0d hs=%b vs=%b de=%b exp h=%0d v=%0d hs=%b vs=%b de=%b",
                 n, obs_a.h, obs_a.v, obs_a.hs, obs_a.vs, obs_a.de, e.h, e.v, e.hs, e.vs, e.de);
      end
      e = ref_pos(n, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1'b0, 1'b0);
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL small_cycle n=%0d got h=%0d v=%0d hs=%b vs=%b de=%b exp h=%0d v=%0d hs=%b vs=%b de=%b",
                 n, obs_b.h, obs_b.v, obs_b.hs, obs_b.vs, obs_b.de, e.h, e.v, e.hs, e.vs, e.de);
      end
      e = ref_pos(n, PHD, PHF, PHS, PHB, 480, 10, 2, 33, 1'b1, 1'b1);
      checks++;
      if (obs_c !== e) begin
        errors++;
        $display("FAIL pol_cycle n=%0d got h=%0d v=%0d hs=%b vs=%b de=%b exp h=%0d v=%0d hs=%b vs=%b de=%b",
                 n, obs_c.h, obs_c.v, obs_c.hs, obs_c.vs, obs_c.de, e.h, e.v, e.hs, e.vs, e.de);
      end
    end
  endtask

  task automatic test_reset();
    vid_t rst_lo, rst_hi;
    rst_lo = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1};
    rst_hi = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1};
    reset = 1'b0;
    repeat ($urandom_range(3, 10)) begin
      @(posedge clk); #1;
      checks += 3;
      if (obs_a !== rst_lo) begin errors++; $display("FAIL reset_def got %h exp %h", obs_a, rst_lo); end
      if (obs_b !== rst_lo) begin errors++; $display("FAIL reset_small got %h exp %h", obs_b, rst_lo); end
      if (obs_c !== rst_hi) begin errors++; $display("FAIL reset_pol got %h exp %h", obs_c, rst_hi); end
    end
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (a_h !== 10'd1 || a_v !== 10'd0) begin errors++; $display("FAIL first_edge_def got h=%0d v=%0d exp h=1 v=0", a_h, a_v); end
    if (b_h !== 10'd1 || b_v !== 10'd0) begin errors++; $display("FAIL first_edge_small got h=%0d v=%0d exp h=1 v=0", b_h, b_v); end
    if (c_h !== 10'd1 || c_v !== 10'd0) begin errors++; $display("FAIL first_edge_pol got h=%0d v=%0d exp h=1 v=0", c_h, c_v); end
  endtask

  task automatic test_async_reset(input int run_first);
    vid_t rst_lo, rst_hi;
    rst_lo = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1};
    rst_hi = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1};
    test_free_run(run_first);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (obs_a !== rst_lo) begin errors++; $display("FAIL async_reset_def got %h exp %h", obs_a, rst_lo); end
    if (obs_b !== rst_lo) begin errors++; $display("FAIL async_reset_small got %h exp %h", obs_b, rst_lo); end
    if (obs_c !== rst_hi) begin errors++; $display("FAIL async_reset_pol got %h exp %h", obs_c, rst_hi); end
    @(posedge clk); #1;
    checks++;
    if (obs_a !== rst_lo) begin errors++; $display("FAIL reset_hold_def got %h exp %h", obs_a, rst_lo); end
    test_first_edge();
  endtask

  task automatic test_line_scan();
    int a_hs_lo = 0, a_de_hi = 0, c_hs_hi = 0, c_de_hi = 0, c_zero = 0;
    int b_vs_lo = 0, b_de_hi = 0, a_hmax = 0;
    test_free_run(1);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (a_hs === 1'b0) a_hs_lo++;
      if (a_de === 1'b1) a_de_hi++;
      if (int'(a_h) > a_hmax) a_hmax = int'(a_h);
      if (i < 400) begin
        if (c_hs === 1'b1) c_hs_hi++;
        if (c_de === 1'b1) c_de_hi++;
        if (c_h === 10'd0) c_zero++;
      end
      if (i < 300) begin
        if (b_vs === 1'b0) b_vs_lo++;
        if (b_de === 1'b1) b_de_hi++;
      end
    end
    checks += 8;
    if (a_hs_lo != 96)  begin errors++; $display("FAIL def_hsync_width got %0d exp 96", a_hs_lo); end
    if (a_de_hi != 640) begin errors++; $display("FAIL def_display_clocks got %0d exp 640", a_de_hi); end
    if (a_hmax != 799)  begin errors++; $display("FAIL def_hpos_max got %0d exp 799", a_hmax); end
    if (c_hs_hi != 32)  begin errors++; $display("FAIL pol_hsync_width got %0d exp 32", c_hs_hi); end
    if (c_de_hi != 320) begin errors++; $display("FAIL pol_display_clocks got %0d exp 320", c_de_hi); end
    if (c_zero != 1)    begin errors++; $display("FAIL pol_line_length got %0d zeros exp 1", c_zero); end
    if (b_vs_lo != SVS * (SHD + SHF + SHS + SHB)) begin
      errors++; $display("FAIL small_vsync_clocks got %0d exp %0d", b_vs_lo, SVS * (SHD + SHF + SHS + SHB));
    end
    if (b_de_hi != SHD * SVD) begin
      errors++; $display("FAIL small_display_clocks got %0d exp %0d", b_de_hi, SHD * SVD);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_async_reset(299);
    test_line_scan();
    test_free_run(1700);
    for (int k = 0; k < 4; k++) begin
      test_async_reset(int'($urandom_range(1, 900)));
      test_free_run(int'($urandom_range(10, 400)));
    end
    test_reset();
    test_first_edge();
    test_free_run(850);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hvsync_generator.md
HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning), one per line:
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in clocks.
- H_SYNC, 96, horizontal sync width, in clocks.
- H_BACK, 48, horizontal back porch, in clocks.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- H_SYNC_POL, 0, hsync level while sync is asserted (0 = active-low).
- V_SYNC_POL, 0, vsync level while sync is asserted (0 = active-low).

REQ-002 The module SHALL have these ports (name, direction, width, meaning), one per line:
- clk  input  1  pixel clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- display_on  output  1  high while (hpos, vpos) is inside the visible area.
- hpos  output  10  current pixel column.
- vpos  output  10  current line.

REQ-003 One clock domain only; reset is asynchronous and active-low, and no other reset or enable input exists.

Function
REQ-004 Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 at defaults); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 at defaults); both SHALL be <= 1024.
REQ-005 hpos SHALL increment by 1 every clock, and wrap from H_TOTAL-1 to 0.
REQ-006 vpos SHALL increment by 1 only on the clock where hpos wraps; it wraps from V_TOTAL-1 to 0 on that same edge.
REQ-007 hpos and vpos SHALL be registered outputs and never take values >= H_TOTAL or >= V_TOTAL respectively.
REQ-008 hsync SHALL equal H_SYNC_POL when H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751 at defaults), and ~H_SYNC_POL otherwise.
REQ-009 vsync SHALL equal V_SYNC_POL when V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491 at defaults), and ~V_SYNC_POL otherwise; vsync is asserted for whole lines, including their blanking clocks.
REQ-010 display_on SHALL be 1 exactly when hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-011 hsync, vsync and display_on SHALL be registered, glitch-free outputs, computed from the next-state counter values so that they correspond to the hpos/vpos visible in the same cycle (zero cycles of skew).
REQ-012 Counter arithmetic SHALL be 10-bit unsigned, with wrap performed by explicit compare-to-total, never by natural overflow.
REQ-013 The module SHALL free-run with no handshake; the only input affecting it besides clk is reset.

Reset
REQ-014 While reset is low, regardless of clk: hpos=0, vpos=0, display_on=1, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL.
REQ-015 Reset assertion SHALL take effect immediately, mid-line or mid-frame, and abandon the current frame.
REQ-016 On the first rising clk edge after reset deasserts, hpos SHALL become 1 and vpos SHALL stay 0.
REQ-017 With reset held low permanently, the outputs SHALL remain at the REQ-014 values indefinitely.

Verification
REQ-018 Release reset at defaults and run 800 clocks -> hpos sequence 0..799 then 0; vpos steps 0->1 exactly on the wrap edge.
REQ-019 Scan one full line at defaults -> hsync low for exactly 96 consecutive clocks with hpos 656..751; display_on high for hpos 0..639 only.
REQ-020 Run a full frame (420000 clocks) -> vsync low only for vpos 490 and 491 (1600 clocks total); vpos wraps 524->0 when hpos wraps 799->0; display_on never high for vpos >= 480.
REQ-021 Assert reset at hpos=300, vpos=200, asynchronously between edges -> outputs go to the REQ-014 values immediately without a clk edge; after release, counting restarts from (0,0).
REQ-022 Set parameters H_SYNC_POL=1, V_SYNC_POL=1, H_DISPLAY=320, H_FRONT=8, H_SYNC=32, H_BACK=40 -> line length 400; hsync high for hpos 328..359; display_on high for hpos 0..319.
REQ-023 A bench checker SHALL confirm on every cycle that display_on matches REQ-010 from the same-cycle hpos/vpos (zero skew).
